// File: rtl/pipeline_block_fifo.sv
// pipeline_block_fifo: elastic valid/ready stage with a DEPTH-entry payload
// buffer, a thread-stall 'block' input and a synchronous flush.
// Optional build macro: PIPELINE_BLOCK_STAT_EN adds o_block_cycles, a
// saturating count of cycles where upstream offers data while blocked.
module pipeline_block_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2,
  parameter int BLOCK_OUT = 0,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              block,
  input  logic              flush,
  output logic [CNT_W-1:0]  o_count,
`ifdef PIPELINE_BLOCK_STAT_EN
  output logic [31:0]       o_block_cycles,
`endif
  output logic              o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              blk_out;
  logic              push;
  logic              pop;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Handshake: i_ready looks at o_ready only when the buffer is full, which
  // lets a full stage accept and release in the same cycle (zero bubble).
  always_comb begin
    blk_out = (BLOCK_OUT != 0) && block;
    o_valid = (count != '0) && !blk_out;
    pop     = o_valid && o_ready;
    i_ready = !block && !flush && ((count < CNT_W'(DEPTH)) || pop);
    push    = i_valid && i_ready;
  end

  // Occupancy and pointer update; flush overrides any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; push is never true during flush since i_ready is low.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  assign o_data  = mem[rd_ptr];
  assign o_count = count;
  assign o_full  = (count == CNT_W'(DEPTH));

`ifdef PIPELINE_BLOCK_STAT_EN
  logic [31:0] block_cycles;

  // Count upstream-offered cycles lost to block, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_cycles <= '0;
    end else if (flush) begin
      block_cycles <= '0;
    end else if (i_valid && block && (block_cycles != '1)) begin
      block_cycles <= block_cycles + 32'd1;
    end
  end

  assign o_block_cycles = block_cycles;
`endif

  // Occupancy can never exceed the buffer depth.
  count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(DEPTH));

endmodule

// File: doc/pipeline_block_fifo.md
Name: pipeline_block_fifo

Overview:
Parametrised elastic pipeline stage for the valid/ready datapath (Montgomery/RSA pipeline). It carries a DATA_W payload through a DEPTH-entry buffer. A 'block' control stalls the thread at this point, and a flush drops in-flight data. It replaces single-bit blocking stages wherever payload buffering, deeper decoupling or output-side blocking is needed.

Parameters:
DATA_W, 32, payload width in bits (>=1)
DEPTH, 2, buffer entries (>=1; any integer, not only powers of two)
BLOCK_OUT, 0, 0: block gates the input side only and buffered data keeps draining; 1: block gates input and output
CNT_W, $clog2(DEPTH+1), width of o_count (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream data valid
i_ready  out  1  stage accepts i_data this cycle
i_data  in  DATA_W  upstream payload
o_valid  out  1  head entry valid downstream
o_ready  in  1  downstream accepts head
o_data  out  DATA_W  head payload
block  in  1  stall thread at this stage
flush  in  1  synchronous discard of all buffered entries
o_count  out  CNT_W  current occupancy, 0..DEPTH
o_full  out  1  o_count == DEPTH

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While reset is asserted, count=0, read/write pointers=0, o_valid=0, o_full=0, o_count=0. Storage contents are don't-care; o_data is don't-care while o_valid=0.
- Definitions:
  - blk_out = BLOCK_OUT && block
  - o_valid = (count != 0) && !blk_out
  - pop = o_valid && o_ready
  - i_ready = !block && !flush && (count < DEPTH || pop)
  - push = i_valid && i_ready
- i_ready may depend combinationally on o_ready, but only in the full case. This matches the existing zero-bubble chaining.
- Latency: data pushed into an empty buffer at cycle N appears on o_valid/o_data at cycle N+1. No combinational i_data->o_data path.
- Order: strict FIFO. o_data is always the oldest entry.
- Occupancy update:
  - push and pop: count unchanged. Write at wr_ptr, read from rd_ptr, both advance.
  - push only: count+1.
  - pop only: count-1.
  - Neither: hold.
- Pointers wrap from DEPTH-1 to 0; non-power-of-two DEPTH must wrap explicitly.
- Full with pop: push is accepted in the same cycle and count stays at DEPTH.
- Empty with push and o_ready both high: no bypass. o_valid rises next cycle.
- Block:
  - While block=1, i_ready=0 and no push occurs.
  - BLOCK_OUT=0: buffered entries continue to drain.
  - BLOCK_OUT=1: o_valid=0, state frozen, contents preserved. Output resumes with the same head the cycle block deasserts.
- Flush:
  - Highest priority. On a clk edge with flush=1, count and pointers go to 0 regardless of push/pop.
  - i_ready=0 during flush, so upstream never sees a false accept.
  - o_valid may be 1 in the flush cycle. If o_ready is also 1 the head is transferred, then the rest is dropped.
- Downstream contract: o_valid/o_data stay stable while o_valid && !o_ready, unless flush or blk_out.
- Reset asserted mid-operation: all entries lost immediately, o_valid=0 asynchronously.

Optional Feature:
PIPELINE_BLOCK_STAT_EN
- Defined: adds output o_block_cycles (32 bits). Counts cycles with i_valid && block, saturating at 32'hFFFF_FFFF. Cleared by reset and by flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- DEPTH=2, block=0: push 0xA1, 0xA2, 0xA3 with o_ready=1 every cycle -> o_data 0xA1,0xA2,0xA3 on cycles 1,2,3 after each push; o_count never exceeds 1; i_ready constant 1.
- DEPTH=3, o_ready=0: push 4 items -> first 3 accepted, o_full=1, i_ready=0 on 4th. Raise o_ready with i_valid held -> pop 1st and push 4th in the same cycle, o_count stays 3.
- BLOCK_OUT=0, count=2, block=1, o_ready=1 -> i_ready=0, both entries drain in 2 cycles, then o_valid=0. BLOCK_OUT=1, same stimulus -> o_valid=0, count held at 2; release block -> original head reappears.
- count=3, flush=1 with i_valid=1 and o_ready=0 -> i_ready=0 that cycle, next cycle o_count=0, o_valid=0, the offered input is not accepted.
- DEPTH=3 (non-power-of-two): stream 10 items with random o_ready -> output order 0..9 preserved across pointer wrap. Assert rst_n low mid-stream -> o_valid drops immediately, o_count=0.
- With PIPELINE_BLOCK_STAT_EN: i_valid=1, block=1 for 5 cycles -> o_block_cycles=5; flush -> 0.
